// File: rtl/soin_bpred_pkg.sv
// Shared branch-predictor resolve definitions: meta field layout, counter limits,
// queue entry format and the saturating counter update.
package soin_bpred_pkg;

   localparam int BP_META_WIDTH = 18;

   localparam int META_IDX_LSB = 0;
   localparam int META_IDX_W   = 12;
   localparam int META_CNT_LSB = 12;
   localparam int META_CNT_W   = 2;
   localparam int META_RAS_LSB = 14;
   localparam int META_RAS_W   = 4;

   localparam logic [1:0] CNT_MAX = 2'd3;
   localparam logic [1:0] CNT_MIN = 2'd0;

   typedef struct packed {
      logic [META_IDX_W-1:0] index;
      logic [META_CNT_W-1:0] counter;
   } upq_entry_t;

   function automatic logic [1:0] cnt_update(input logic [1:0] cnt, input logic taken);
      if (taken) return (cnt == CNT_MAX) ? CNT_MAX : cnt + 2'd1;
      else       return (cnt == CNT_MIN) ? CNT_MIN : cnt - 2'd1;
   endfunction

endpackage

// File: rtl/soin_bpred_upq.sv
// Predictor update queue: FIFO of {index, counter} with a youngest-match lookup
// so a new update can build on counters that have not reached the table yet.
module soin_bpred_upq
   import soin_bpred_pkg::*;
#(
   parameter int Q_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push_i,
   input  logic [META_IDX_W-1:0] push_index_i,
   input  logic [META_CNT_W-1:0] push_counter_i,
   input  logic                  pop_i,
   input  logic [META_IDX_W-1:0] lookup_index_i,
   output logic                  hit_o,
   output logic [META_CNT_W-1:0] hit_counter_o,
   output logic                  valid_o,
   output logic [META_IDX_W-1:0] head_index_o,
   output logic [META_CNT_W-1:0] head_counter_o,
   output logic                  full_o
);

   localparam int PW = $clog2(Q_DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;
   upq_entry_t    mem_q [Q_DEPTH];

   logic full, empty, do_push, do_pop;
   logic [PW-1:0] slot;

   assign full    = (count_q == CW'(Q_DEPTH));
   assign empty   = (count_q == '0);
   assign do_pop  = pop_i & ~empty;
   // A push into a full queue only lands when the head leaves in the same cycle.
   assign do_push = push_i & (~full | pop_i);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         count_q <= count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   // NOTE: storage is deliberately not reset; occupancy gates every read, so
   // stale contents are never observable and the array maps onto plain flops/RAM.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= '{index: push_index_i, counter: push_counter_i};
   end

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      hit_o         = 1'b0;
      hit_counter_o = '0;
      slot          = rd_ptr_q;
      for (int i = 0; i < Q_DEPTH; i++) begin
         slot = rd_ptr_q + PW'(i);
         if ((CW'(i) < count_q) && (mem_q[slot].index == lookup_index_i)) begin
            hit_o         = 1'b1;
            hit_counter_o = mem_q[slot].counter;
         end
      end
   end

   assign valid_o        = ~empty;
   assign head_index_o   = empty ? '0 : mem_q[rd_ptr_q].index;
   assign head_counter_o = empty ? '0 : mem_q[rd_ptr_q].counter;
   assign full_o         = full;

   a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
      !(push_i && full && !pop_i))
      else $error("update queue push while full without pop");

endmodule

// File: rtl/soin_bpred_resolve.sv
// Execute-stage branch resolution: mispredict redirect and RAS recovery, plus
// queued 2-bit counter updates toward the predictor table.
module soin_bpred_resolve
   import soin_bpred_pkg::*;
#(
   parameter int Q_DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     ex_valid,
   input  logic                     ex_is_cond,
   input  logic                     ex_is_call,
   input  logic                     ex_is_ret,
   input  logic [31:0]              ex_PC,
   input  logic                     ex_dir,
   input  logic [31:0]              ex_target,
   input  logic                     ex_p_dir,
   input  logic [31:0]              ex_p_target,
   input  logic [BP_META_WIDTH-1:0] ex_meta,
   input  logic                     up_stall,
   output logic                     redirect,
   output logic [31:0]              redirect_PC,
   output logic                     recover_ras,
   output logic [3:0]               recover_index,
   output logic                     up_valid,
   output logic [11:0]              up_index,
   output logic [1:0]               up_counter,
   output logic                     q_full
);

   logic        miss_q;
   logic [31:0] redirect_pc_q;
   logic [3:0]  recover_index_q;

   logic        shadow, ex_live, mispredict, miss, push, pop;
   logic        hit;
   logic [1:0]  hit_counter, base_counter, new_counter;
   logic [META_IDX_W-1:0] meta_index;
   logic        unused_class;

   // Call/ret only matter through direction/target; they never update the table.
   assign unused_class = ex_is_call | ex_is_ret;

   assign meta_index = ex_meta[META_IDX_LSB +: META_IDX_W];

   // The cycle right after a registered miss carries a wrong-path instruction.
   assign shadow     = miss_q;
   assign ex_live    = ex_valid & ~shadow;
   assign mispredict = (ex_dir != ex_p_dir) | (ex_dir & (ex_target != ex_p_target));
   assign miss       = ex_live & mispredict;
   assign push       = ex_live & ex_is_cond;
   assign pop        = up_valid & ~up_stall;

   assign base_counter = hit ? hit_counter : ex_meta[META_CNT_LSB +: META_CNT_W];
   assign new_counter  = cnt_update(base_counter, ex_dir);

   always_ff @(posedge clk) begin
      if (!reset) begin
         miss_q          <= 1'b0;
         redirect_pc_q   <= '0;
         recover_index_q <= '0;
      end else begin
         miss_q <= miss;
         if (miss) begin
            redirect_pc_q   <= ex_dir ? ex_target : ex_PC + 32'd4;
            recover_index_q <= ex_meta[META_RAS_LSB +: META_RAS_W];
         end
      end
   end

   assign redirect      = miss_q;
   assign recover_ras   = miss_q;
   assign redirect_PC   = redirect_pc_q;
   assign recover_index = recover_index_q;

   soin_bpred_upq #(.Q_DEPTH(Q_DEPTH)) u_upq (
      .clk            (clk),
      .reset          (reset),
      .push_i         (push),
      .push_index_i   (meta_index),
      .push_counter_i (new_counter),
      .pop_i          (pop),
      .lookup_index_i (meta_index),
      .hit_o          (hit),
      .hit_counter_o  (hit_counter),
      .valid_o        (up_valid),
      .head_index_o   (up_index),
      .head_counter_o (up_counter),
      .full_o         (q_full)
   );

endmodule

// File: tb/tb_soin_bpred_resolve.sv
// Directed bench for soin_bpred_resolve: vector table plus hand sequences for
// bypass/saturation, full-queue pop+push, and reset mid-operation.
module tb_soin_bpred_resolve;

   logic        clk = 1'b0;
   logic        reset;
   logic        ex_valid, ex_is_cond, ex_is_call, ex_is_ret;
   logic [31:0] ex_PC, ex_target, ex_p_target;
   logic        ex_dir, ex_p_dir;
   logic [17:0] ex_meta;
   logic        up_stall;
   logic        redirect, recover_ras, up_valid, q_full;
   logic [31:0] redirect_PC;
   logic [3:0]  recover_index;
   logic [11:0] up_index;
   logic [1:0]  up_counter;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   soin_bpred_resolve #(.Q_DEPTH(4)) dut (
      .clk(clk), .reset(reset),
      .ex_valid(ex_valid), .ex_is_cond(ex_is_cond), .ex_is_call(ex_is_call), .ex_is_ret(ex_is_ret),
      .ex_PC(ex_PC), .ex_dir(ex_dir), .ex_target(ex_target),
      .ex_p_dir(ex_p_dir), .ex_p_target(ex_p_target), .ex_meta(ex_meta),
      .up_stall(up_stall),
      .redirect(redirect), .redirect_PC(redirect_PC),
      .recover_ras(recover_ras), .recover_index(recover_index),
      .up_valid(up_valid), .up_index(up_index), .up_counter(up_counter),
      .q_full(q_full)
   );

   typedef struct {
      logic        v, cond, call;
      logic [31:0] pc;
      logic        dir;
      logic [31:0] tgt;
      logic        pdir;
      logic [31:0] ptgt;
      logic [17:0] meta;
      logic        stall;
      logic        e_red;
      logic [31:0] e_pc;
      logic [3:0]  e_ras;
      logic        e_uv;
      logic [11:0] e_ui;
      logic [1:0]  e_uc;
      logic        e_full;
   } vec_t;

   function automatic logic [17:0] m(input logic [11:0] idx, input logic [1:0] c, input logic [3:0] r);
      return {r, c, idx};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic cond, input logic call, input logic [31:0] pc,
                        input logic dir, input logic [31:0] tgt, input logic pdir,
                        input logic [31:0] ptgt, input logic [17:0] meta, input logic stall);
      ex_valid = v; ex_is_cond = cond; ex_is_call = call; ex_is_ret = 1'b0;
      ex_PC = pc; ex_dir = dir; ex_target = tgt; ex_p_dir = pdir; ex_p_target = ptgt;
      ex_meta = meta; up_stall = stall;
   endtask

   task automatic idle(input logic stall);
      drive(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, '0, stall);
   endtask

   // Correctly predicted conditional branch: pushes an update, never redirects.
   task automatic push_c(input logic [11:0] idx, input logic [1:0] cnt, input logic dir, input logic stall);
      drive(1'b1, 1'b1, 1'b0, 32'h700, dir, 32'h800, dir, 32'h800, m(idx, cnt, 4'h0), stall);
   endtask

   task automatic check_outs(input string tag, input logic e_red, input logic [31:0] e_pc,
                             input logic [3:0] e_ras, input logic e_uv, input logic [11:0] e_ui,
                             input logic [1:0] e_uc, input logic e_full);
      check({tag, " redirect"}, 32'(redirect), 32'(e_red));
      check({tag, " recover_ras"}, 32'(recover_ras), 32'(e_red));
      if (e_red) begin
         check({tag, " redirect_PC"}, redirect_PC, e_pc);
         check({tag, " recover_index"}, 32'(recover_index), 32'(e_ras));
      end
      check({tag, " up_valid"}, 32'(up_valid), 32'(e_uv));
      check({tag, " up_index"}, 32'(up_index), 32'(e_ui));
      check({tag, " up_counter"}, 32'(up_counter), 32'(e_uc));
      check({tag, " q_full"}, 32'(q_full), 32'(e_full));
   endtask

   vec_t vecs [12];

   initial begin
      // Fields: v cond call pc dir tgt pdir ptgt meta stall | red pc ras uv ui uc full
      vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'h100, 1'b1, 32'h140, 1'b0, 32'h0, m(12'h010, 2'd1, 4'h3), 1'b1,
                   1'b1, 32'h140, 4'h3, 1'b1, 12'h010, 2'd2, 1'b0};
      vecs[1]  = '{1'b1, 1'b1, 1'b0, 32'h180, 1'b1, 32'h1C0, 1'b0, 32'h0, m(12'h020, 2'd1, 4'h2), 1'b0,
                   1'b0, '0, '0, 1'b0, '0, '0, 1'b0};
      vecs[2]  = '{1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, '0, 1'b0,
                   1'b0, '0, '0, 1'b0, '0, '0, 1'b0};
      vecs[3]  = '{1'b1, 1'b1, 1'b0, 32'h1F0, 1'b1, 32'h204, 1'b1, 32'h200, m(12'h030, 2'd2, 4'hA), 1'b1,
                   1'b1, 32'h204, 4'hA, 1'b1, 12'h030, 2'd3, 1'b0};
      vecs[4]  = '{1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, '0, 1'b0,
                   1'b0, '0, '0, 1'b0, '0, '0, 1'b0};
      vecs[5]  = '{1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC, 1'b0, 32'h500, 1'b1, 32'h500, m(12'h040, 2'd0, 4'h5), 1'b1,
                   1'b1, 32'h0, 4'h5, 1'b1, 12'h040, 2'd0, 1'b0};
      vecs[6]  = '{1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, '0, 1'b0,
                   1'b0, '0, '0, 1'b0, '0, '0, 1'b0};
      vecs[7]  = '{1'b1, 1'b1, 1'b0, 32'h280, 1'b1, 32'h300, 1'b1, 32'h300, m(12'h050, 2'd2, 4'h1), 1'b1,
                   1'b0, '0, '0, 1'b1, 12'h050, 2'd3, 1'b0};
      vecs[8]  = '{1'b1, 1'b0, 1'b1, 32'h380, 1'b1, 32'h400, 1'b0, 32'h0, m(12'h050, 2'd0, 4'h7), 1'b1,
                   1'b1, 32'h400, 4'h7, 1'b1, 12'h050, 2'd3, 1'b0};
      vecs[9]  = '{1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, '0, 1'b0,
                   1'b0, '0, '0, 1'b0, '0, '0, 1'b0};
      vecs[10] = '{1'b1, 1'b1, 1'b0, 32'h600, 1'b0, 32'h111, 1'b0, 32'h222, m(12'h060, 2'd1, 4'h2), 1'b1,
                   1'b0, '0, '0, 1'b1, 12'h060, 2'd0, 1'b0};
      vecs[11] = '{1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, '0, 1'b0,
                   1'b0, '0, '0, 1'b0, '0, '0, 1'b0};

      reset = 1'b0;
      idle(1'b0);
      tick();
      tick();
      check("reset redirect_PC", redirect_PC, 32'h0);
      check("reset recover_index", 32'(recover_index), 32'h0);
      check_outs("reset", 1'b0, '0, '0, 1'b0, '0, '0, 1'b0);

      reset = 1'b1;
      for (int i = 0; i < 12; i++) begin
         drive(vecs[i].v, vecs[i].cond, vecs[i].call, vecs[i].pc, vecs[i].dir, vecs[i].tgt,
               vecs[i].pdir, vecs[i].ptgt, vecs[i].meta, vecs[i].stall);
         tick();
         check_outs($sformatf("vec%0d", i), vecs[i].e_red, vecs[i].e_pc, vecs[i].e_ras,
                    vecs[i].e_uv, vecs[i].e_ui, vecs[i].e_uc, vecs[i].e_full);
      end

      // Bypass + saturation, then fill to full and pop+push while full.
      push_c(12'h005, 2'd1, 1'b1, 1'b1); tick();
      check_outs("byp1", 1'b0, '0, '0, 1'b1, 12'h005, 2'd2, 1'b0);
      push_c(12'h005, 2'd1, 1'b1, 1'b1); tick();
      check_outs("byp2", 1'b0, '0, '0, 1'b1, 12'h005, 2'd2, 1'b0);
      push_c(12'h005, 2'd1, 1'b1, 1'b1); tick();
      check_outs("byp3", 1'b0, '0, '0, 1'b1, 12'h005, 2'd2, 1'b0);
      push_c(12'h006, 2'd0, 1'b0, 1'b1); tick();
      check_outs("fill4", 1'b0, '0, '0, 1'b1, 12'h005, 2'd2, 1'b1);
      push_c(12'h007, 2'd2, 1'b1, 1'b0); tick();
      check_outs("full_pop_push", 1'b0, '0, '0, 1'b1, 12'h005, 2'd3, 1'b1);
      idle(1'b0); tick();
      check_outs("drain1", 1'b0, '0, '0, 1'b1, 12'h005, 2'd3, 1'b0);
      tick();
      check_outs("drain2", 1'b0, '0, '0, 1'b1, 12'h006, 2'd0, 1'b0);
      tick();
      check_outs("drain3", 1'b0, '0, '0, 1'b1, 12'h007, 2'd3, 1'b0);
      tick();
      check_outs("drain4", 1'b0, '0, '0, 1'b0, '0, '0, 1'b0);

      // Reset with queued entries and a pending redirect.
      push_c(12'h008, 2'd1, 1'b1, 1'b1); tick();
      push_c(12'h009, 2'd2, 1'b1, 1'b1); tick();
      drive(1'b1, 1'b1, 1'b0, 32'hA00, 1'b1, 32'hA40, 1'b0, 32'h0, m(12'h00A, 2'd1, 4'hC), 1'b1);
      tick();
      check_outs("pre_reset", 1'b1, 32'hA40, 4'hC, 1'b1, 12'h008, 2'd2, 1'b0);
      reset = 1'b0;
      idle(1'b1);
      tick();
      check("midreset redirect_PC", redirect_PC, 32'h0);
      check("midreset recover_index", 32'(recover_index), 32'h0);
      check_outs("midreset", 1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
      reset = 1'b1;
      push_c(12'h009, 2'd1, 1'b1, 1'b1); tick();
      check_outs("post_reset_push", 1'b0, '0, '0, 1'b1, 12'h009, 2'd2, 1'b0);

      idle(1'b0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/soin_bpred_resolve.md
SOIN_BPRED_RESOLVE -- requirements
Module: soin_bpred_resolve

Interface
REQ-001 Parameter: Q_DEPTH, 4, update-queue entries (power of 2, 2..16).
REQ-002 clk  in  1  clock; all state on posedge.
REQ-003 reset  in  1  reset, synchronous, active-low; clock clk.
REQ-004 ex_valid  in  1  resolved control-flow instruction present this cycle.
REQ-005 ex_is_cond / ex_is_call / ex_is_ret  in  1 each  branch class from execute decode.
REQ-006 ex_PC  in  32  PC of the resolved instruction.
REQ-007 ex_dir  in  1  actual direction (1 = taken).
REQ-008 ex_target  in  32  actual target.
REQ-009 ex_p_dir / ex_p_target  in  1 / 32  fetch-time prediction carried down the pipe.
REQ-010 ex_meta  in  BP_META_WIDTH  fetch-time meta: [11:0] table index, [13:12] counter read, [17:14] RAS index.
REQ-011 up_stall  in  1  predictor table write port unavailable; hold queue head.
REQ-012 redirect / redirect_PC  out  1 / 32  registered mispredict redirect to fetch.
REQ-013 recover_ras / recover_index  out  1 / 4  RAS pointer restore.
REQ-014 up_valid / up_index / up_counter  out  1 / 12 / 2  table write (head of queue).
REQ-015 q_full  out  1  queue full; execute must hold ex_valid.

Function
REQ-016 miss = ex_valid & (ex_dir != ex_p_dir | (ex_dir & ex_target != ex_p_target)), computed combinationally.
REQ-017 redirect asserts one cycle after a miss, for exactly one cycle; redirect_PC = ex_dir ? ex_target : ex_PC+4 (32-bit wrap).
REQ-018 Shadow: the ex_valid cycle immediately after a registered miss is wrong-path and is ignored (no queue push, no redirect).
REQ-019 recover_ras pulses with redirect; recover_index = ex_meta[17:14] of the missing instruction.
REQ-020 Only ex_is_cond entries push to the queue; call/ret/others never update the table.
REQ-021 New counter: 2-bit saturating, +1 if taken (sat 3), -1 if not-taken (sat 0).
REQ-022 Base counter = value of the youngest queued entry with equal index if one exists, else ex_meta[13:12] (bypass of stale reads).
REQ-023 Queue: FIFO, Q_DEPTH entries of {index, counter}; push on eligible ex_valid, pop when up_valid & ~up_stall.
REQ-024 up_valid = queue non-empty; up_index/up_counter = head entry; empty -> up_valid=0, index/counter 0.
REQ-025 Push and pop same cycle when full: both occur, occupancy unchanged, q_full stays 1.
REQ-026 Push while full with no pop: entry dropped, no state change (protocol violation flagged by assertion).
REQ-027 Pointers wrap modulo Q_DEPTH; occupancy counter width clog2(Q_DEPTH)+1.
REQ-028 q_full = (occupancy == Q_DEPTH), registered-state derived, no combinational path from ex_*.

Reset
REQ-029 While reset=0 at posedge: queue empty, pointers 0, redirect=0, recover_ras=0, shadow flag 0, redirect_PC=0, recover_index=0.
REQ-030 Reset mid-operation discards all queued updates and any pending redirect; first legal push is the cycle after reset releases.

Structure
REQ-031 BP_META_WIDTH (18), meta field offsets, and counter saturation constants live in the shared header.
REQ-032 One sub-module: soin_bpred_upq (parameterised FIFO with index-match bypass lookup).
REQ-033 Estimated size 150-300 lines.

Verification
REQ-034 Cond at PC 0x100, p_dir=0, dir=1, target 0x140, meta counter 1 -> next cycle redirect=1, redirect_PC=0x140; queue push counter 2.
REQ-035 Cond p_dir=1, p_target=0x200, dir=1, target=0x204 -> miss; redirect_PC=0x204, recover_index = meta[17:14].
REQ-036 Three back-to-back taken cond pushes, index 0x05, meta counter 1, up_stall=1 -> queued counters 2, 3, 3 (bypass + saturation).
REQ-037 Fill 4 entries with up_stall=1 -> q_full=1; release up_stall with a simultaneous push -> pop+push, occupancy stays 4.
REQ-038 Miss followed by ex_valid next cycle -> second instruction ignored, no push, single redirect pulse.
REQ-039 Reset=0 with 2 queued entries and pending redirect -> next cycle up_valid=0, redirect=0, q_full=0.
